samul_div_sequential: RTL
=========================

# samul_div_sequential

Multi-cycle restoring divider that inverts the sequential multiplier path. It divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and remainder. A start/busy/done handshake controls it, and it retires one quotient bit per iteration. It sits beside the sequential multiplier in the arithmetic datapath, so a product can be round-tripped back to its operands.

## Interface
- WIDTH, 32, divisor/quotient/remainder width; dividend is 2·WIDTH bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- dividend  input  2·WIDTH  sampled on the accepted start edge.
- divisor  input  WIDTH  sampled on the accepted start edge.
- busy  output  1  high while state is RUN.
- done  output  1  single-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  held until the next accepted start.
- remainder  output  WIDTH  held until the next accepted start.
- div_by_zero  output  1  error flag, valid with done and held.
- overflow  output  1  error flag, valid with done and held.

## Operation
- States: IDLE and RUN.
- Start is accepted when start=1 in IDLE. Start in RUN is ignored and does not queue.
- On accept, div_by_zero and overflow are cleared, then the operands are checked in this priority:
  - divisor==0: stay in IDLE. Next edge sets done=1, div_by_zero=1, quotient=all ones, remainder=dividend[WIDTH-1:0].
  - dividend[2W-1:W] >= divisor: stay in IDLE. Next edge sets done=1, overflow=1, quotient=all ones, remainder=0.
  - otherwise go to RUN. Load partial remainder R (WIDTH+1 bits) = dividend[2W-1:W], quotient shift register Q = dividend[W-1:0], iteration count = 0.
- Each RUN iteration:
  - Shift {R,Q} left by 1.
  - Compute trial T = R − {0,divisor} as a (WIDTH+1)-bit result.
  - If T is non-negative (MSB=0): R=T and Q[0]=1. Otherwise Q[0]=0.
- After WIDTH iterations:
  - quotient=Q and remainder=R[W-1:0].
  - done pulses for one cycle, busy drops, and the state returns to IDLE.
- Invariant on a normal completion: quotient·divisor + remainder == dividend, and remainder < divisor.
- A new start is accepted in the same cycle that done is high (back-to-back operation).
- Reset (rst=0) at any time, including mid-RUN:
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - All internal registers and counters are cleared.
  - The in-flight operation is discarded and no done is produced.

## Timing
- Reset value of every output is 0.
- Edge 0 is the start-accept edge. Error cases: done is high in the cycle after edge 0 (latency 1).
- Normal case without the macro:
  - iterations occur on edges 1..WIDTH.
  - busy is high for exactly WIDTH cycles.
  - done is high in the cycle after edge WIDTH (latency 32 for the default WIDTH).
- Normal case with the macro: see Configuration.
- done and busy are never high in the same cycle.

## Configuration
- SAMUL_DIV_SLOW_STEP_EN
  - Defined: iterations advance only on an internal step strobe, produced by a 2-bit counter cleared on start accept that fires when it equals 3. The first iteration is at edge 4 and the last at edge 4·WIDTH (latency 128 for the default WIDTH). busy covers the whole interval. Results are bit-identical to the undefined case.
  - Undefined: one iteration per clk and no counter logic.
  - Error-case latency is 1 in both builds.

## Test plan
- Small divide: dividend=100, divisor=7 -> quotient=14, remainder=2, done at cycle 32 after start, busy high for 32 cycles, flags 0.
- Full-scale inverse of the multiplier: dividend=64'hFFFF_FFFE_0000_0001, divisor=32'hFFFF_FFFF -> quotient=32'hFFFF_FFFF, remainder=0.
- Divide by zero: dividend=64'h1234_5678_9ABC_DEF0, divisor=0 -> done after 1 cycle, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h9ABC_DEF0, busy never high.
- Overflow: dividend=64'h0000_0005_0000_0000, divisor=5 -> done after 1 cycle, overflow=1, quotient=32'hFFFF_FFFF, remainder=0.
- Reset mid-run:
  - Pull rst low at cycle 10 of a 100/7 run -> all outputs 0 immediately, no done.
  - After release, start 1000/3 -> quotient=333, remainder=1.
- Handshake:
  - start held high throughout a run -> re-accepted only in the done cycle.
  - A second start pulse mid-RUN -> ignored and the result is unchanged.
  - Repeat the whole plan with SAMUL_DIV_SLOW_STEP_EN defined -> same results, normal latency 128.

Source files
------------

// File: rtl/samul_div_sequential_if.sv
// samul_div_sequential_if: start/busy/done handshake with operand and result bundle for the divider
interface samul_div_sequential_if #(parameter int WIDTH = 32);
  logic start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  logic overflow;
  modport master (
    output start, dividend, divisor,
    input busy, done, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/samul_div_sequential.sv
// samul_div_sequential: restoring 2W/W divider, one quotient bit per step; SAMUL_DIV_SLOW_STEP_EN steps every 4th clk
module samul_div_sequential #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  samul_div_sequential_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] t;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic accept;
  logic step;
  logic last;
  logic [WIDTH-1:0] hi;
`ifdef SAMUL_DIV_SLOW_STEP_EN
  logic [1:0] sub;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sub <= '0;
    else sub <= accept ? 2'd0 : sub + 2'd1;
  assign step = sub == 2'd3;
`else
  assign step = 1'b1;
`endif
  // partial remainder stays below divisor, so only the shifted trial needs the extra bit
  always_comb begin
    hi = bus.dividend[2*WIDTH-1:WIDTH];
    accept = state == IDLE && bus.start;
    r_sh = {r, q[WIDTH-1]};
    t = r_sh - {1'b0, d};
    r_nx = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_nx = {q[WIDTH-2:0], ~t[WIDTH]};
    last = step && cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        bus.div_by_zero <= bus.divisor == '0;
        bus.overflow <= bus.divisor != '0 && hi >= bus.divisor;
        if (bus.divisor == '0) begin
          bus.done <= 1'b1;
          bus.quotient <= '1;
          bus.remainder <= bus.dividend[WIDTH-1:0];
        end else if (hi >= bus.divisor) begin
          bus.done <= 1'b1;
          bus.quotient <= '1;
          bus.remainder <= '0;
        end else begin
          state <= RUN;
          bus.busy <= 1'b1;
          r <= hi;
          q <= bus.dividend[WIDTH-1:0];
          d <= bus.divisor;
          cnt <= '0;
        end
      end else if (state == RUN && step) begin
        r <= r_nx;
        q <= q_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.quotient <= q_nx;
          bus.remainder <= r_nx;
        end
      end
    end
endmodule
